// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Holds the shadow-entry struct and a saturating-add helper for the optional statistics.
package fwd_pkg;

  localparam int REG_AW   = 5;
  localparam int SEL_RF   = 0;
  localparam int SB_LAT_W = 8;   // storage width for the latency field; top zero-extends ex_lat into it

  localparam logic [REG_AW-1:0] X0        = 5'd0;
  localparam logic [REG_AW-1:0] ECALL_REG = 5'd17;

  typedef struct packed {
    logic                v;
    logic [REG_AW-1:0]   rd;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One EX source operand checked against every tracked entry.
// Reports whether the youngest matching producer exists, its select code, and whether it is forwardable.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic                    src_valid,
  input  logic [REG_AW-1:0]       src_addr,
  input  sb_entry_t [DEPTH-1:0]   entries,
  output logic                    hit,
  output logic [SEL_W-1:0]        sel,
  output logic                    ready
);

  // Walk oldest to youngest so the youngest match is the last assignment and wins.
  always_comb begin
    hit   = 1'b0;
    sel   = SEL_W'(SEL_RF);
    ready = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_valid && (src_addr != X0) && entries[k].v && (entries[k].rd == src_addr)) begin
        hit   = 1'b1;
        sel   = SEL_W'(k + 1);
        ready = (k >= int'(entries[k].lat));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: shadow pipeline of in-flight destinations after EX, per-operand
// forward selects and a load-use stall. Optional statistics counters under FWD_STATS_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 3,
  parameter  int LAT_W   = 2,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_freeze,
  input  logic                        ex_valid,
  input  logic                        ex_flush,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_reg_write,
  input  logic [LAT_W-1:0]            ex_lat,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall_req,
  output logic [31:0]                 stat_fwd_cnt,
  output logic [31:0]                 stat_stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [NUM_SRC-1:0]    hit, rdy;
  logic                  push;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .src_valid (src_valid[i]),
      .src_addr  (src_addr[i*REG_AW +: REG_AW]),
      .entries   (entries_q),
      .hit       (hit[i]),
      .sel       (fwd_sel[i*SEL_W +: SEL_W]),
      .ready     (rdy[i])
    );
  end

  assign stall_req = |(hit & ~rdy);

  // A stalled EX instruction is not accepted; a bubble goes in behind the producer instead.
  assign push = ex_valid & ex_reg_write & (ex_rd != X0) & ~ex_flush & ~stall_req;

  always_comb begin
    entries_d = entries_q;
    if (!pipe_freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--)
        entries_d[k] = entries_q[k-1];
      entries_d[0] = '0;
      if (push) begin
        entries_d[0].v   = 1'b1;
        entries_d[0].rd  = ex_rd;
        entries_d[0].lat = SB_LAT_W'(ex_lat);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) entries_q <= '0;
    else       entries_q <= entries_d;
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] n_fwd;

  // Forwards only count on cycles where EX actually advances.
  always_comb begin
    n_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++)
      n_fwd = n_fwd + 32'(hit[i]);
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!pipe_freeze) begin
      if (stall_req) stall_cnt_d = sat_add32(stall_cnt_q, 32'd1);
      else           fwd_cnt_d   = sat_add32(fwd_cnt_q, n_fwd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios then random traffic, all checked against
// a model that tracks in-flight producers by age.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int NS = 3;
  localparam int DP = 3;
  localparam int LW = 2;
  localparam int SW = $clog2(DP + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_freeze, ex_valid, ex_flush, ex_reg_write;
  logic [4:0]        ex_rd;
  logic [LW-1:0]     ex_lat;
  logic [NS-1:0]     src_valid;
  logic [NS*5-1:0]   src_addr;
  logic [NS*SW-1:0]  fwd_sel;
  logic              stall_req;
  logic [31:0]       stat_fwd_cnt, stat_stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_SRC(NS), .DEPTH(DP), .LAT_W(LW)) dut (
    .clk(clk), .reset(reset), .pipe_freeze(pipe_freeze), .ex_valid(ex_valid),
    .ex_flush(ex_flush), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_lat(ex_lat),
    .src_valid(src_valid), .src_addr(src_addr), .fwd_sel(fwd_sel), .stall_req(stall_req),
    .stat_fwd_cnt(stat_fwd_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always @(posedge clk)
    if (!reset && ex_valid && !pipe_freeze)
      assert (int'(ex_lat) < DP) else $error("illegal ex_lat %0d", ex_lat);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model: each tracked producer carries its age (cycles since it left EX).
  typedef struct { int rd; int lat; int age; } prod_t;
  prod_t mq[$];
  longint m_fwd, m_stall;

  function automatic int m_win(int i);
    int addr, best, bage;
    addr = int'(src_addr[i*5 +: 5]);
    best = -1;
    bage = 1000;
    if (src_valid[i] && addr != 0)
      foreach (mq[j])
        if (mq[j].rd == addr && mq[j].age < bage) begin
          bage = mq[j].age;
          best = j;
        end
    return best;
  endfunction

  function automatic int m_sel(int i);
    int w;
    w = m_win(i);
    return (w < 0) ? 0 : mq[w].age + 1;
  endfunction

  function automatic bit m_stall_now();
    bit s;
    int w;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      w = m_win(i);
      if (w >= 0 && mq[w].age < mq[w].lat) s = 1;
    end
    return s;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NS; i++)
      chk($sformatf("%s sel%0d", tag, i), 32'(fwd_sel[i*SW +: SW]), 32'(m_sel(i)));
    chk({tag, " stall"}, 32'(stall_req), 32'(m_stall_now()));
`ifdef FWD_STATS_EN
    chk({tag, " fwd_cnt"}, stat_fwd_cnt, 32'(m_fwd));
    chk({tag, " stall_cnt"}, stat_stall_cnt, 32'(m_stall));
`else
    chk({tag, " fwd_cnt"}, stat_fwd_cnt, 32'd0);
    chk({tag, " stall_cnt"}, stat_stall_cnt, 32'd0);
`endif
  endtask

  task automatic tick();
    bit st;
    int nf;
    prod_t nq[$];
    @(posedge clk);
    if (!reset && !pipe_freeze) begin
      st = m_stall_now();
      nf = 0;
      for (int i = 0; i < NS; i++) if (m_sel(i) != 0) nf++;
      if (st) m_stall++; else m_fwd += nf;
      foreach (mq[j]) if (mq[j].age + 1 < DP) nq.push_back('{mq[j].rd, mq[j].lat, mq[j].age + 1});
      if (ex_valid && ex_reg_write && ex_rd != 0 && !ex_flush && !st)
        nq.push_back('{int'(ex_rd), int'(ex_lat), 0});
      mq = nq;
    end
    #1;
  endtask

  task automatic drv(input bit fz, input bit vld, input bit fl, input int rd, input bit rw,
                     input int lat, input bit [2:0] sv, input int a0, input int a1, input int a2);
    pipe_freeze  = fz;
    ex_valid     = vld;
    ex_flush     = fl;
    ex_rd        = 5'(rd);
    ex_reg_write = rw;
    ex_lat       = LW'(lat);
    src_valid    = sv;
    src_addr     = {5'(a2), 5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
  endtask

  initial begin
    int rd;
    reset = 1'b1;
    m_fwd = 0;
    m_stall = 0;
    drv(0, 1, 0, 5, 1, 0, 3'b111, 5, 6, 17);
    repeat (2) @(posedge clk);
    #2;
    chk("reset sel", 32'(fwd_sel), 32'd0);
    chk("reset stall", 32'(stall_req), 32'd0);
    reset = 1'b0;
    idle();
    check_all("post_reset");
    tick();

    // ALU result forwarded from entry0
    drv(0, 1, 0, 5, 1, 0, 3'b000, 0, 0, 0); check_all("t1a"); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b001, 5, 0, 0);
    chk("t1 sel0", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("t1 stall", 32'(stall_req), 32'd0);
    check_all("t1b"); tick();

    // load-use: one stall, then forward from entry1
    drv(0, 1, 0, 6, 1, 1, 3'b000, 0, 0, 0); check_all("t2a"); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b010, 0, 6, 0);
    chk("t2 sel1 stall", 32'(fwd_sel[SW +: SW]), 32'd1);
    chk("t2 stall", 32'(stall_req), 32'd1);
    check_all("t2b"); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b010, 0, 6, 0);
    chk("t2 sel1 after", 32'(fwd_sel[SW +: SW]), 32'd2);
    chk("t2 stall after", 32'(stall_req), 32'd0);
    check_all("t2c"); tick();

    // youngest match wins; x0 never matches
    drv(0, 1, 0, 7, 1, 0, 3'b000, 0, 0, 0); check_all("t3a"); tick();
    idle(); check_all("t3b"); tick();
    drv(0, 1, 0, 7, 1, 0, 3'b000, 0, 0, 0); check_all("t3c"); tick();
    drv(0, 1, 0, 0, 1, 0, 3'b001, 7, 0, 0);
    chk("t3 prio sel0", 32'(fwd_sel[0 +: SW]), 32'd1);
    check_all("t3d"); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0);
    chk("t3 x0 sel", 32'(fwd_sel), 32'd0);
    chk("t3 x0 stall", 32'(stall_req), 32'd0);
    check_all("t3e"); tick();

    // ecall port tracks x17 at distance 3, then it retires
    drv(0, 1, 0, int'(ECALL_REG), 1, 0, 3'b000, 0, 0, 0); check_all("t4a"); tick();
    idle(); tick();
    idle(); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 17);
    chk("t4 sel2 dist3", 32'(fwd_sel[2*SW +: SW]), 32'd3);
    check_all("t4b"); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 17);
    chk("t4 sel2 retired", 32'(fwd_sel[2*SW +: SW]), 32'd0);
    check_all("t4c"); tick();

    // freeze holds state; flushed producer never appears
    drv(0, 1, 0, 8, 1, 0, 3'b000, 0, 0, 0); tick();
    for (int c = 0; c < 4; c++) begin
      drv(1, 1, 0, 10, 1, 0, 3'b011, 8, 10, 0);
      chk($sformatf("t5 frz%0d sel0", c), 32'(fwd_sel[0 +: SW]), 32'd1);
      check_all("t5 frz"); tick();
    end
    drv(0, 1, 1, 9, 1, 0, 3'b001, 8, 0, 0); check_all("t5 flush"); tick();
    for (int c = 0; c < 3; c++) begin
      drv(0, 0, 0, 0, 0, 0, 3'b001, 9, 0, 0);
      chk($sformatf("t5 x9 sel0 %0d", c), 32'(fwd_sel[0 +: SW]), 32'd0);
      check_all("t5 x9"); tick();
    end

    // reset while stalled clears outputs immediately
    drv(0, 1, 0, 11, 1, 1, 3'b000, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 3'b001, 11, 0, 0);
    chk("t6 pre stall", 32'(stall_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6 rst stall", 32'(stall_req), 32'd0);
    chk("t6 rst sel", 32'(fwd_sel), 32'd0);
    chk("t6 rst fwd_cnt", stat_fwd_cnt, 32'd0);
    chk("t6 rst stall_cnt", stat_stall_cnt, 32'd0);
    mq.delete();
    m_fwd = 0;
    m_stall = 0;
    tick();
    reset = 1'b0;

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rd = ($urandom_range(0, 3) == 0) ? 17 : $urandom_range(0, 7);
      drv($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          rd, $urandom_range(0, 4) != 0, $urandom_range(0, DP - 1), 3'($urandom()),
          $urandom_range(0, 7), $urandom_range(0, 7),
          ($urandom_range(0, 1) == 0) ? 17 : $urandom_range(0, 7));
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
